// File: rtl/noise_word_arbiter.sv
// noise_word_arbiter: collects serial LFSR bits into words and hands each word to one requester round-robin.
// The LFSR is frozen while a finished word waits for a grant, so no sequence bits are dropped.
module noise_word_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 8,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic               i_clock,
    input  logic               i_reset_l,
    input  logic               i_run,
    input  logic               i_lfsr_q,
    output logic               o_lfsr_en,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_grant_id,
    output logic [WORD_W-1:0]  o_rand_word,
    output logic               o_word_ready
);
    localparam int CNT_W = $clog2(WORD_W);

    typedef enum logic {FILL, READY} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [WORD_W-1:0]   r_shift;
    logic [WORD_W-1:0]   r_rand_word;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_grant_id;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [ID_W-1:0]     w_win;
    logic                w_last;
    logic                w_grant;
    int                  w_p;

    // lfsr_en is gated by reset so it reads 0 while reset is held, even with run=1
    assign o_lfsr_en    = i_reset_l & i_run & (r_state == FILL);
    assign o_word_ready = (r_state == READY);
    assign o_gnt        = r_gnt;
    assign o_grant_id   = r_grant_id;
    assign o_rand_word  = r_rand_word;
    assign w_last       = o_lfsr_en && (r_bit_cnt == CNT_W'(WORD_W - 1));
    assign w_grant      = (r_state == READY) && (|i_req);

    // Scan downward so the lowest offset from ptr is the one left standing
    always_comb begin
        w_win = '0;
        w_p   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_p = int'(r_ptr) + k;
            if (w_p >= NUM_REQ) w_p = w_p - NUM_REQ;
            if (i_req[w_p]) w_win = ID_W'(w_p);
        end
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == FILL) ? (w_last ? READY : FILL) : (w_grant ? FILL : READY);
    end

    always_ff @(posedge i_clock or negedge i_reset_l) begin
        if (!i_reset_l) r_state <= FILL;
        else r_state <= w_next;
    end

    always_ff @(posedge i_clock or negedge i_reset_l) begin
        if (!i_reset_l) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rand_word <= '0;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_gnt       <= '0;
        end else begin
            r_gnt <= '0;
            if (o_lfsr_en) begin
                r_shift   <= {r_shift[WORD_W-2:0], i_lfsr_q};
                r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
                if (w_last) r_rand_word <= {r_shift[WORD_W-2:0], i_lfsr_q};
            end
            if (w_grant) begin
                r_gnt      <= NUM_REQ'(1) << w_win;
                r_grant_id <= w_win;
                r_ptr      <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_noise_word_arbiter.sv
// tb_noise_word_arbiter: directed and random stimulus against a word-level reference model.
module tb_noise_word_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       lfsr_q;
    logic       lfsr_en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] grant_id;
    logic [7:0] rand_word;
    logic       word_ready;

    noise_word_arbiter #(.NUM_REQ(4), .WORD_W(8)) dut (
        .i_clock(clk), .i_reset_l(rst_n), .i_run(run), .i_lfsr_q(lfsr_q),
        .o_lfsr_en(lfsr_en), .i_req(req), .o_gnt(gnt), .o_grant_id(grant_id),
        .o_rand_word(rand_word), .o_word_ready(word_ready)
    );

    always #5 clk = ~clk;

    bit pat [0:1023];
    int pidx;
    assign lfsr_q = pat[pidx % 1024];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pidx <= 0;
        else if (lfsr_en) pidx <= pidx + 1;
    end

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int m_taken, m_ptr, m_gid, cyc, last_g;
    bit m_ready, track;
    logic [7:0] m_word;
    int gq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_lfsr_en", lfsr_en, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_rand_word", rand_word, 0);
        chk("rst_word_ready", word_ready, 0);
        m_taken = 0; m_ptr = 0; m_gid = -1; m_ready = 0; m_word = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive, check combinational outputs, advance model across the edge, check registered outputs
    task automatic tick(input bit r, input logic [3:0] q);
        run = r; req = q;
        #1;
        chk("lfsr_en", lfsr_en, {31'd0, !m_ready && r});
        chk("word_ready", word_ready, {31'd0, m_ready});
        @(posedge clk);
        cyc++;
        m_gid = -1;
        if (m_ready) begin
            for (int k = 0; k < 4; k++)
                if (m_gid < 0 && q[(m_ptr + k) % 4]) m_gid = (m_ptr + k) % 4;
            if (m_gid >= 0) begin
                m_ptr = (m_gid + 1) % 4;
                m_ready = 0;
            end
        end else if (r) begin
            m_taken++;
            if (m_taken % 8 == 0) begin
                m_ready = 1;
                for (int i = 0; i < 8; i++) m_word = {m_word[6:0], pat[(m_taken - 8 + i) % 1024]};
            end
        end
        #1;
        chk("gnt", gnt, m_gid >= 0 ? 32'd1 << m_gid : 32'd0);
        if (m_gid >= 0) chk("grant_id", grant_id, m_gid);
        chk("rand_word", rand_word, m_word);
        if (track && gnt != 0) begin
            gq.push_back(grant_id);
            if (last_g >= 0) chk("gnt_gap", cyc - last_g, 9);
            last_g = cyc;
        end
        @(negedge clk);
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        cyc = 0; track = 0; last_g = -1;
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1;
        pat[4] = 0; pat[5] = 0; pat[6] = 1; pat[7] = 0;
        for (int i = 8; i < 1024; i++) pat[i] = 1'($urandom);
        rst_n = 1'b1; run = 1'b0; req = 4'b0;
        #2;
        do_reset();

        // 1: first word B2, held with no requests
        for (int i = 0; i < 8; i++) tick(1, 4'b0000);
        chk("t1_word", rand_word, 8'hB2);
        chk("t1_ready", word_ready, 1);
        for (int i = 0; i < 20; i++) tick(1, 4'b0000);

        // 2: all requesting, round-robin at one grant per 9 cycles
        do_reset();
        track = 1;
        for (int i = 0; i < 45; i++) tick(1, 4'b1111);
        track = 0;
        chk("t2_count", gq.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++) chk("t2_order", gq[i], exp_order[i]);

        // 3: grant 2 moves ptr to 3, so 3 beats 0
        do_reset();
        for (int i = 0; i < 9; i++) tick(1, 4'b0100);
        for (int i = 0; i < 9; i++) tick(1, 4'b1001);
        chk("t3_id", grant_id, 3);
        for (int i = 0; i < 9; i++) tick(1, 4'b1001);

        // 4: pause after 3 bits, word still B2
        do_reset();
        for (int i = 0; i < 3; i++) tick(1, 4'b0000);
        for (int i = 0; i < 5; i++) tick(0, 4'b0000);
        for (int i = 0; i < 5; i++) tick(1, 4'b0000);
        chk("t4_word", rand_word, 8'hB2);

        // 5: async reset mid-fill and in READY
        do_reset();
        for (int i = 0; i < 5; i++) tick(1, 4'b0000);
        run = 1;
        do_reset();
        for (int i = 0; i < 8; i++) tick(1, 4'b0000);
        chk("t5_word", rand_word, 8'hB2);
        run = 1;
        do_reset();
        for (int i = 0; i < 9; i++) tick(1, 4'b0000);

        // 6: request withdrawn while word waits
        do_reset();
        for (int i = 0; i < 8; i++) tick(1, 4'b0010);
        for (int i = 0; i < 5; i++) tick(1, 4'b0000);
        tick(1, 4'b0010);

        // random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            tick($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
